// File: rtl/readpixel_pkg.sv
// Shared NeoPixel receive constants, FSM state codes and cycle helpers.
// Imported by the decoder top and its input synchroniser.
package readpixel_pkg;

    localparam int CLK_HZ_DEF      = 12_000_000;
    localparam int T_THRESH_NS_DEF = 600;
    localparam int T_MIN_NS_DEF    = 150;
    localparam int T_MAX_NS_DEF    = 2000;
    localparam int T_LATCH_US_DEF  = 50;

    localparam int CW = 16;
    localparam int PW = 24;

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_FWD  = 3'd5;

    // Whole-MHz clock times nanoseconds, truncated to cycles.
    function automatic logic [CW-1:0] ns_to_cyc(input int clk_hz, input int ns);
        return CW'((clk_hz / 1_000_000) * ns / 1000);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

endpackage

// File: rtl/readpixel_sync2.sv
// Two-flop synchroniser for an asynchronous pin plus edge detect.
// rise/fall compare the synchronised level against its registered copy.
module readpixel_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d_in,
    output logic d_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic d_s_q;

    // Metastability chain and one-cycle history for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta  <= 1'b0;
            d_s   <= 1'b0;
            d_s_q <= 1'b0;
        end else begin
            meta  <= d_in;
            d_s   <= meta;
            d_s_q <= d_s;
        end
    end

    assign rise = d_s & ~d_s_q;
    assign fall = ~d_s & d_s_q;

endmodule

// File: rtl/readpixel.sv
// WS2812 receive-side decoder: captures the first GRB word after a latch
// and forwards the rest of the frame on d_out, like a real pixel.
module readpixel
    import readpixel_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEF,
    parameter int T_THRESH_NS = T_THRESH_NS_DEF,
    parameter int T_MIN_NS    = T_MIN_NS_DEF,
    parameter int T_MAX_NS    = T_MAX_NS_DEF,
    parameter int T_LATCH_US  = T_LATCH_US_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          d_in,
    output logic          d_out,
    output logic [PW-1:0] pixel_data,
    output logic          pixel_valid,
    input  logic          pixel_ready,
    output logic          latch,
    output logic          frame_err,
    output logic          overrun
);

    localparam logic [CW-1:0] THRESH = ns_to_cyc(CLK_HZ, T_THRESH_NS);
    localparam logic [CW-1:0] MIN    = ns_to_cyc(CLK_HZ, T_MIN_NS);
    localparam logic [CW-1:0] MAX    = ns_to_cyc(CLK_HZ, T_MAX_NS);
    localparam logic [CW-1:0] LATCH  = ns_to_cyc(CLK_HZ, T_LATCH_US * 1000);

    logic          d_s;
    logic          rise;
    logic          fall;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] lcnt;
    logic [2:0]    state;
    logic [4:0]    bit_cnt;
    logic [PW-1:0] sr;
    logic          lat_hit;
    logic          too_long;

    readpixel_sync2 u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .d_in (d_in),
        .d_s  (d_s),
        .rise (rise),
        .fall (fall)
    );

    // A latch only counts while the line is still low; an edge restarts it.
    assign lat_hit  = !d_s && (lcnt == LATCH);
    assign too_long = hcnt > MAX;

    // Saturating high/low run-length counters; hcnt counts high cycles after the rising edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            if (rise)
                hcnt <= '0;
            else if (d_s)
                hcnt <= sat_inc(hcnt);
            if (fall)
                lcnt <= '0;
            else if (!d_s)
                lcnt <= sat_inc(lcnt);
        end
    end

    // Bit classifier, word assembly, handshake and forwarding FSM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_SYNC;
            bit_cnt     <= '0;
            sr          <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            overrun     <= 1'b0;
            latch       <= 1'b0;
            frame_err   <= 1'b0;
            d_out       <= 1'b0;
        end else begin
            latch     <= 1'b0;
            frame_err <= 1'b0;
            d_out     <= (state == S_FWD) && !lat_hit && d_s;
            if (pixel_valid && pixel_ready)
                pixel_valid <= 1'b0;
            unique case (state)
                S_SYNC: begin
                    if (lat_hit)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (lat_hit)
                        latch <= 1'b1;
                    else if (rise)
                        state <= S_HIGH;
                end
                S_HIGH: begin
                    if (fall) begin
                        if (hcnt < MIN) begin
                            state <= (bit_cnt == 5'd0) ? S_IDLE : S_LOW;
                        end else if (too_long) begin
                            frame_err <= 1'b1;
                            state     <= S_SYNC;
                        end else begin
                            sr      <= {sr[PW-2:0], hcnt >= THRESH};
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= (bit_cnt == 5'd23) ? S_DONE : S_LOW;
                        end
                    end else if (too_long) begin
                        frame_err <= 1'b1;
                        state     <= S_SYNC;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state <= S_HIGH;
                    end else if (lat_hit) begin
                        latch     <= 1'b1;
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DONE: begin
                    pixel_data  <= sr;
                    pixel_valid <= 1'b1;
                    if (pixel_valid && !pixel_ready)
                        overrun <= 1'b1;
                    state <= S_FWD;
                end
                S_FWD: begin
                    if (lat_hit) begin
                        latch <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_readpixel.sv
// Randomised bench for readpixel: drives WS2812 waveforms and compares
// against a word-level model of capture, forwarding and handshake.
module tb_readpixel;

    localparam int DEPTH = 32768;

    logic        CLK = 1'b0;
    logic        RST;
    logic        d_in;
    logic        pixel_ready;
    logic        d_out;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        latch;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_latch = 0;
    int n_err = 0;
    int n_both = 0;
    int last_err = 0;
    bit din_h [DEPTH];
    bit dout_h [DEPTH];

    logic [23:0] exp_data;
    bit          exp_valid;
    bit          exp_ovr;

    logic [23:0] w;
    logic [23:0] ws [3];
    int          nw;
    int          s0;
    int          w2s;
    int          l0;
    int          e0;
    int          b0;
    int          ones;
    int          p0;

    readpixel dut (
        .CLK         (CLK),
        .RST         (RST),
        .d_in        (d_in),
        .d_out       (d_out),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .latch       (latch),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    // Record line history and count output pulses away from the active edge
    always @(negedge CLK) begin
        din_h[cyc % DEPTH]  <= d_in;
        dout_h[cyc % DEPTH] <= d_out;
        cyc <= cyc + 1;
        if (latch)
            n_latch <= n_latch + 1;
        if (frame_err) begin
            n_err    <= n_err + 1;
            last_err <= cyc;
        end
        if (latch && frame_err)
            n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            d_in = v;
            @(posedge CLK);
            #1;
        end
    endtask

    // '1' = 10 high / 5 low, '0' = 5 high / 10 low; gl splits the low with a 1-cycle spike
    task automatic send_bit(input bit b, input bit gl);
        drive(1'b1, b ? 10 : 5);
        if (gl) begin
            drive(1'b0, 2);
            drive(1'b1, 1);
            drive(1'b0, b ? 2 : 7);
        end else begin
            drive(1'b0, b ? 5 : 10);
        end
    endtask

    task automatic send_word(input logic [23:0] wd, input bit gl);
        for (int i = 23; i >= 0; i--)
            send_bit(wd[i], gl && (i > 0));
    endtask

    task automatic model_word(input logic [23:0] wd);
        if (exp_valid)
            exp_ovr = 1'b1;
        exp_valid = 1'b1;
        exp_data  = wd;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_data"}, 32'(pixel_data), 32'(exp_data));
        chk({tag, "_valid"}, 32'(pixel_valid), 32'(exp_valid));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic consume(input string tag);
        pixel_ready = 1'b1;
        @(posedge CLK);
        #1;
        pixel_ready = 1'b0;
        exp_valid   = 1'b0;
        chk({tag, "_consumed"}, 32'(pixel_valid), 32'(exp_valid));
    endtask

    // d_out must replay d_in three cycles late from the second word on, else stay 0
    task automatic fwd_check(input string tag, input int from, input int fstart);
        int  bad;
        bit  e;
        bad = 0;
        for (int t = from; t < cyc; t++) begin
            e = (t - 3 >= fstart) ? din_h[(t - 3) % DEPTH] : 1'b0;
            if (dout_h[t % DEPTH] != e)
                bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    function automatic int count_dout(input int from);
        int n;
        n = 0;
        for (int t = from; t < cyc; t++)
            n += int'(dout_h[t % DEPTH]);
        return n;
    endfunction

    initial begin
        RST         = 1'b1;
        d_in        = 1'b0;
        pixel_ready = 1'b0;
        exp_data    = '0;
        exp_valid   = 1'b0;
        exp_ovr     = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dout", 32'(d_out), 32'd0);
        chk("rst_latch", 32'(latch), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk_out("rst");
        RST = 1'b0;

        // Initial sync period: no pulses
        drive(1'b0, 700);
        chk("sync_latch", 32'(n_latch), 32'd0);
        chk("sync_err", 32'(n_err), 32'd0);

        // Single word frame
        w  = 24'hFF0055;
        s0 = cyc;
        l0 = n_latch;
        e0 = n_err;
        send_word(w, 1'b0);
        drive(1'b0, 650);
        model_word(w);
        chk_out("t1");
        chk("t1_latch", 32'(n_latch - l0), 32'd1);
        chk("t1_err", 32'(n_err - e0), 32'd0);
        chk("t1_dout_quiet", 32'(count_dout(s0)), 32'd0);
        consume("t1");

        // Multi-word frames with random data: capture first, forward the rest
        for (int k = 0; k < 3; k++) begin
            nw = 2 + (k % 2);
            for (int j = 0; j < 3; j++)
                ws[j] = 24'($urandom);
            if (k == 0) begin
                ws[0] = 24'h123456;
                ws[1] = 24'hABCDEF;
            end
            s0 = cyc;
            l0 = n_latch;
            e0 = n_err;
            send_word(ws[0], 1'b0);
            w2s = cyc;
            for (int j = 1; j < nw; j++)
                send_word(ws[j], 1'b0);
            drive(1'b0, 650);
            model_word(ws[0]);
            chk_out("t2");
            chk("t2_latch", 32'(n_latch - l0), 32'd1);
            chk("t2_err", 32'(n_err - e0), 32'd0);
            fwd_check("t2_fwd", s0, w2s);
            consume("t2");
        end

        // Partial word then latch: discarded with err+latch together
        w  = 24'($urandom);
        l0 = n_latch;
        e0 = n_err;
        b0 = n_both;
        for (int i = 23; i >= 12; i--)
            send_bit(w[i], 1'b0);
        drive(1'b0, 650);
        chk_out("t3");
        chk("t3_latch", 32'(n_latch - l0), 32'd1);
        chk("t3_err", 32'(n_err - e0), 32'd1);
        chk("t3_both", 32'(n_both - b0), 32'd1);
        w = 24'($urandom);
        send_word(w, 1'b0);
        drive(1'b0, 650);
        model_word(w);
        chk_out("t3_next");
        consume("t3");

        // Over-long high mid-word: error, then ignore the line until a full low period
        w  = 24'($urandom);
        l0 = n_latch;
        e0 = n_err;
        for (int i = 23; i >= 19; i--)
            send_bit(w[i], 1'b0);
        p0 = cyc;
        drive(1'b1, 30);
        drive(1'b0, 10);
        chk("t4_err", 32'(n_err - e0), 32'd1);
        chk("t4_err_during_high", 32'((last_err - p0 >= 24) && (last_err - p0 <= 32)), 32'd1);
        send_word(24'($urandom), 1'b0);
        drive(1'b0, 650);
        chk_out("t4_ignored");
        chk("t4_no_latch", 32'(n_latch - l0), 32'd0);
        chk("t4_err_once", 32'(n_err - e0), 32'd1);
        // Glitch spikes before and inside a word do not shift
        w  = 24'($urandom);
        l0 = n_latch;
        e0 = n_err;
        drive(1'b1, 1);
        drive(1'b0, 20);
        send_word(w, 1'b1);
        drive(1'b0, 650);
        model_word(w);
        chk_out("t4_glitch");
        chk("t4_glitch_latch", 32'(n_latch - l0), 32'd1);
        chk("t4_glitch_err", 32'(n_err - e0), 32'd0);
        consume("t4");

        // Two unconsumed words: overrun sticks after consume
        send_word(24'h000001, 1'b0);
        drive(1'b0, 650);
        model_word(24'h000001);
        chk_out("t5_first");
        send_word(24'h000002, 1'b0);
        drive(1'b0, 650);
        model_word(24'h000002);
        chk_out("t5_second");
        consume("t5");
        chk("t5_ovr_sticky", 32'(overrun), 32'(exp_ovr));

        // Reset mid-word, release while the line is still toggling
        w = 24'($urandom);
        for (int i = 23; i >= 14; i--)
            send_bit(w[i], 1'b0);
        RST = 1'b1;
        send_bit(w[13], 1'b0);
        send_bit(w[12], 1'b0);
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        chk_out("t6_rst");
        chk("t6_rst_dout", 32'(d_out), 32'd0);
        RST = 1'b0;
        l0 = n_latch;
        e0 = n_err;
        for (int i = 11; i >= 0; i--)
            send_bit(w[i], 1'b0);
        send_word(24'($urandom), 1'b0);
        drive(1'b0, 650);
        chk_out("t6_ignored");
        chk("t6_no_latch", 32'(n_latch - l0), 32'd0);
        chk("t6_no_err", 32'(n_err - e0), 32'd0);
        w = 24'($urandom);
        send_word(w, 1'b0);
        drive(1'b0, 650);
        model_word(w);
        chk_out("t6_after");
        chk("t6_latch", 32'(n_latch - l0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
